// File: rtl/weight_sram_pkg.sv
// weight_sram_pkg: weight SRAM geometry, reader FSM states and range-check helper
package weight_sram_pkg;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 18;
  localparam int WEIGHT_WORDS = 81920;
  localparam int BANK_WORDS = 16384;
  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, DONE, ERR} wsr_state_e;
  function automatic logic in_range(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] len);
    return ({1'b0, base} + {1'b0, len}) <= (ADDR_W+1)'(WEIGHT_WORDS);
  endfunction
endpackage

// File: rtl/weight_stream_reader_if.sv
// weight_stream_reader_if: SRAM read port plus the weight stream toward the PE array
interface weight_stream_reader_if;
  import weight_sram_pkg::*;
  logic mem_cs;
  logic mem_oe;
  logic mem_W_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_W_data;
  logic [31:0] mem_R_data;
  logic w_valid;
  logic w_ready;
  logic [DATA_W-1:0] w_data;
  modport master(output mem_cs, mem_oe, mem_W_req, mem_addr, mem_W_data, w_valid, w_data,
                 input mem_R_data, w_ready);
  modport slave(input mem_cs, mem_oe, mem_W_req, mem_addr, mem_W_data, w_valid, w_data,
                output mem_R_data, w_ready);
endinterface

// File: rtl/weight_fifo.sv
// weight_fifo: synchronous FIFO; push on full is accepted only alongside a pop
module weight_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/weight_stream_reader.sv
// weight_stream_reader: credit-throttled burst reader from weight SRAM into a stream FIFO.
// Define WSR_STALL_CNT_EN to add the saturating stall_cnt output.
module weight_stream_reader
  import weight_sram_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic              err,
`ifdef WSR_STALL_CNT_EN
  output logic [31:0]       stall_cnt,
`endif
  weight_stream_reader_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  wsr_state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, rem_q;
  logic inflight_q, err_q, accept, cs, pop, full, empty, unused_hi;
  logic [CW-1:0] count;
  assign accept = start && state_q == IDLE;
  // credit ignores a same-cycle pop so cs never depends combinationally on w_ready
  assign cs = state_q == ISSUE && (32'(count) + 32'(inflight_q) < FIFO_DEPTH);
  assign pop = bus.w_valid && bus.w_ready;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign err = err_q;
  assign bus.mem_cs = cs;
  assign bus.mem_oe = busy;
  assign bus.mem_W_req = 1'b1;
  assign bus.mem_W_data = '0;
  assign bus.mem_addr = 32'(addr_q);
  assign bus.w_valid = !empty;
  assign unused_hi = ^bus.mem_R_data[31:DATA_W];
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = !in_range(base_addr, length) ? ERR : length == '0 ? DONE : ISSUE;
      ISSUE: if (cs && rem_q == ADDR_W'(1)) state_d = DRAIN;
      DRAIN: if (!inflight_q && (empty || (count == CW'(1) && pop))) state_d = DONE;
      ERR: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      rem_q <= '0;
      inflight_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      inflight_q <= cs;
      if (accept) begin
        addr_q <= base_addr;
        rem_q <= length;
        err_q <= !in_range(base_addr, length);
      end else if (cs) begin
        addr_q <= addr_q + 1'b1;
        rem_q <= rem_q - 1'b1;
      end
    end
  end
  weight_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
    .clk(clk), .rst(rst), .push(inflight_q), .pop(pop),
    .wdata(bus.mem_R_data[DATA_W-1:0]), .rdata(bus.w_data),
    .full(full), .empty(empty), .count(count)
  );
  always_ff @(posedge clk)
    if (!rst) assert (!(inflight_q && full && !pop));
`ifdef WSR_STALL_CNT_EN
  always_ff @(posedge clk)
    if (rst || accept) stall_cnt <= '0;
    else if (bus.w_valid && !bus.w_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
`endif
endmodule
